// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: shared FSM state, response-cause encoding and select-width helper.
package apb_requester_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic [1:0] {CAUSE_OKAY, CAUSE_SLVERR, CAUSE_TIMEOUT, CAUSE_DECERR} cause_e;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: counts stalled ACCESS cycles; constant-zero when TIMEOUT is 0.
module apb_timeout_counter #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : (en && TIMEOUT > 0) ? cnt_q + W'(1) : cnt_q;
  assign expired = (TIMEOUT > 0) && (cnt_q == W'(TIMEOUT));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/apb_requester.sv
// apb_requester: turns a valid/ready command stream into APB2/3/4 transfers
// with one registered response per command, timeout and bad-select handling.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int VERSION    = 4,
  parameter int PSEL_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0,
  localparam int SEL_WIDTH = sel_width(PSEL_WIDTH)
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [SEL_WIDTH-1:0]    cmd_sel,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [PSEL_WIDTH-1:0]   psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  state_e st_q, st_d;
  cause_e cause_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [2:0]              prot_q;
  logic                    write_q;
  logic ready_eff, err_eff, bad, accept, complete, expired, abort;

  // APB2 completers have no wait states and no error signalling
  assign ready_eff = (VERSION < 3) ? 1'b1 : pready;
  assign err_eff   = (VERSION < 3) ? 1'b0 : pslverr;
  assign bad       = int'(cmd_sel) >= PSEL_WIDTH;
  assign accept    = (st_q == ST_IDLE) && cmd_valid;
  assign complete  = (st_q == ST_ACCESS) && ready_eff;
  assign abort     = (st_q == ST_ACCESS) && !ready_eff && expired;

  apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(pclk),
    .rst(preset),
    .clr(st_q == ST_SETUP),
    .en((st_q == ST_ACCESS) && !ready_eff && !expired),
    .expired(expired)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:   st_d = cmd_valid ? (bad ? ST_RESP : ST_SETUP) : ST_IDLE;
      ST_SETUP:  st_d = ST_ACCESS;
      ST_ACCESS: st_d = (complete || abort) ? ST_RESP : ST_ACCESS;
      ST_RESP:   st_d = rsp_ready ? ST_IDLE : ST_RESP;
      default:   st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset)
    if (preset) st_q <= ST_IDLE;
    else st_q <= st_d;

  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      cause_q <= CAUSE_OKAY;
    end else begin
      if (accept && !bad) begin
        sel_q   <= cmd_sel;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        strb_q  <= (VERSION >= 4 && cmd_write) ? cmd_strb : '0;
        prot_q  <= (VERSION >= 4) ? cmd_prot : 3'b0;
        write_q <= cmd_write;
      end
      if (accept && bad) begin
        cause_q <= CAUSE_DECERR;
        rdata_q <= '0;
      end
      if (complete) begin
        cause_q <= err_eff ? CAUSE_SLVERR : CAUSE_OKAY;
        rdata_q <= (!write_q && !err_eff) ? prdata : '0;
      end
      if (abort) begin
        cause_q <= CAUSE_TIMEOUT;
        rdata_q <= '0;
      end
    end

  assign cmd_ready   = st_q == ST_IDLE;
  assign rsp_valid   = st_q == ST_RESP;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = cause_q != CAUSE_OKAY;
  assign rsp_timeout = cause_q == CAUSE_TIMEOUT;
  assign psel        = (st_q == ST_SETUP || st_q == ST_ACCESS) ? PSEL_WIDTH'(1) << sel_q : '0;
  assign penable     = st_q == ST_ACCESS;
  assign pwrite      = write_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign pprot       = prot_q;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed vectors against hand-computed APB/response values.
module tb_apb_requester;
  logic        pclk = 1'b0, preset = 1'b1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [1:0]  cmd_sel = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic [2:0]  cmd_prot = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, prdata = 0;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready = 0, pslverr = 0;
  int n_vec = 0, n_err = 0;

  apb_requester #(.VERSION(4), .PSEL_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  // drive a command for one handshake edge; afterwards the DUT is in SETUP (or RESP on bad select)
  task automatic issue(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    cmd_valid = 1; cmd_write = wr; cmd_sel = sel; cmd_addr = addr;
    cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    chk("cmd_ready_idle", cmd_ready, 1);
    step;
    cmd_valid = 0;
  endtask

  task automatic finish_rsp;
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    chk("rsp_valid_dropped", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outputs", {psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    step;
    preset = 0;
    step;

    // zero-wait read
    pready = 1; prdata = 32'hDEADBEEF;
    issue(0, 0, 32'h10, 0, 4'hF, 0);
    chk("rd_setup_psel", {psel, penable}, {3'b001, 1'b0});
    chk("rd_setup_paddr", paddr, 32'h10);
    chk("rd_pstrb_zero", pstrb, 0);
    chk("rd_cmd_ready_busy", cmd_ready, 0);
    step;
    chk("rd_access", {psel, penable, rsp_valid}, {3'b001, 1'b1, 1'b0});
    step;
    chk("rd_rsp", {rsp_valid, rsp_slverr, rsp_timeout, psel, penable}, {1'b1, 1'b0, 1'b0, 3'b000, 1'b0});
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    prdata = 0;
    finish_rsp;

    // write on completer 2 with three wait states
    pready = 0;
    issue(1, 2, 32'h200, 32'h12345678, 4'h5, 3'b010);
    chk("wr_setup", {psel, penable, pwrite}, {3'b100, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step;
      chk("wr_access_ctrl", {psel, penable, rsp_valid}, {3'b100, 1'b1, 1'b0});
      chk("wr_access_req", {paddr, pwdata}, {32'h200, 32'h12345678});
      chk("wr_access_sp", {pstrb, pprot}, {4'h5, 3'b010});
      pready = (i == 3);
    end
    step;
    chk("wr_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b100);
    chk("wr_rdata", rsp_rdata, 0);
    chk("wr_hold_req", {paddr, pwdata, pstrb}, {32'h200, 32'h12345678, 4'h5});
    finish_rsp;

    // completer error on a read
    pready = 1; pslverr = 1; prdata = 32'h55AA55AA;
    issue(0, 1, 32'h44, 0, 0, 0);
    chk("err_setup_psel", psel, 3'b010);
    step;
    step;
    chk("err_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b110);
    chk("err_rdata", rsp_rdata, 0);
    pslverr = 0;
    finish_rsp;

    // timeout: five ACCESS cycles (count 0..4), then abort
    pready = 0;
    issue(0, 0, 32'h80, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("tmo_access", {psel, penable, rsp_valid}, {3'b001, 1'b1, 1'b0});
    end
    step;
    chk("tmo_rsp", {rsp_valid, rsp_slverr, rsp_timeout, psel, penable}, {3'b111, 3'b000, 1'b0});
    chk("tmo_rdata", rsp_rdata, 0);
    finish_rsp;

    // pready on the cycle the count reaches the limit wins
    issue(0, 0, 32'h84, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("tmo_edge_access", {penable, rsp_valid}, 2'b10);
    end
    pready = 1; prdata = 32'hCAFEF00D;
    step;
    chk("tmo_edge_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b100);
    chk("tmo_edge_rdata", rsp_rdata, 32'hCAFEF00D);
    finish_rsp;

    // bad select with response backpressure
    issue(0, 3, 32'h99, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bad_rsp", {rsp_valid, rsp_slverr, rsp_timeout, cmd_ready}, 4'b1100);
      chk("bad_no_apb", {psel, penable}, 0);
      chk("bad_paddr_held", paddr, 32'h84);
      step;
    end
    finish_rsp;

    // reset during an ACCESS wait state
    pready = 0;
    issue(1, 1, 32'h300, 32'hA5A5A5A5, 4'hF, 0);
    step;
    step;
    chk("rst_mid_pre", {psel, penable}, {3'b010, 1'b1});
    preset = 1;
    #1;
    chk("rst_mid_drop", {psel, penable, rsp_valid, cmd_ready}, {3'b000, 1'b0, 1'b0, 1'b1});
    #1 preset = 0;
    step;
    pready = 1; prdata = 32'h0BADF00D;
    issue(0, 2, 32'h400, 0, 0, 0);
    chk("post_rst_setup", {psel, paddr}, {3'b100, 32'h400});
    step;
    step;
    chk("post_rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b100);
    chk("post_rst_rdata", rsp_rdata, 32'h0BADF00D);
    finish_rsp;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
